pw_pattern_sender: RTL and testbench
====================================

# pw_pattern_sender

Byte-stream pattern transmitter: on a start pulse, plays a programmed pattern of up to pPATTERN_BYTES bytes onto a valid/ready byte interface, with a programmable inter-byte gap and repeat count. It is the transmit-side counterpart of the front-end pattern matcher. It drives the same fe_data/fe_data_valid byte format, with byte 0 taken from I_pattern[7:0]. It is used for self-test loopback into the matcher and for stimulus injection.

## Interface
- pPATTERN_BYTES, 8, maximum pattern length in bytes; I_pattern width is pPATTERN_BYTES*8.
- fe_clk  input  1  sole clock; all logic is on its rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- I_start  input  1  one-cycle start request; ignored while O_busy=1.
- I_abort  input  1  stops an in-progress transfer; takes precedence over all other activity.
- I_pattern  input  pPATTERN_BYTES*8  pattern bytes; byte k = I_pattern[8k+7:8k].
- I_pattern_bytes  input  8  number of bytes to send; values above pPATTERN_BYTES are clamped to pPATTERN_BYTES.
- I_gap  input  8  idle cycles inserted after each accepted byte, except the final byte of the transfer.
- I_repeat  input  8  number of extra pattern passes; 0 means send the pattern once.
- I_fe_ready  input  1  downstream accepts a byte when high together with O_fe_data_valid.
- O_fe_data  output  8  current byte; reset value 0x00.
- O_fe_data_valid  output  1  byte present; reset value 0.
- O_busy  output  1  transfer in progress; reset value 0.
- O_done  output  1  one-cycle pulse on normal completion; reset value 0.

## Operation
- Configuration capture at an accepted start:
  - I_pattern, clamped I_pattern_bytes, I_gap and I_repeat are latched.
  - Input changes after the start have no effect until the next start.
- States:
  - IDLE: O_busy=0, O_fe_data_valid=0.
  - SEND: O_fe_data_valid=1, O_fe_data = latched byte[idx].
  - GAP: O_fe_data_valid=0; counts down the latched gap.
  - DONE: single cycle; O_done=1, then returns to IDLE.
- Transitions:
  - IDLE -> SEND on I_start when latched length >= 1.
  - IDLE -> DONE on I_start when latched length = 0. No byte is sent; O_done still pulses.
  - SEND, accepted byte (valid & ready), not last byte of last pass:
    - gap = 0: stay in SEND with idx advanced.
    - gap > 0: go to GAP with idx advanced.
  - SEND, accepted byte, last byte of last pass -> DONE.
  - GAP -> SEND after exactly I_gap cycles.
- Index and pass counting:
  - idx runs 0 .. len-1, then wraps to 0 and the pass counter increments.
  - The last pass is pass number I_repeat; total bytes sent = len*(I_repeat+1).
  - Counters are wide enough for 255 repeats and a 255-cycle gap with no overflow.
- Handshake rules:
  - While O_fe_data_valid=1 and I_fe_ready=0, O_fe_data is held stable and valid stays high.
  - Abort is the only exception to this rule.
- Abort:
  - I_abort=1 in any non-IDLE state forces IDLE on the next edge.
  - Valid and busy drop; no O_done pulse.
  - A byte with valid & ready in the abort cycle counts as delivered to downstream, but the transfer does not continue.
- Simultaneous I_start and I_abort in IDLE: abort wins, no transfer starts.
- I_start while busy is ignored; it is not queued.
- Reset mid-transfer: all outputs return to their reset values immediately (asynchronous) and the state is IDLE.

## Timing
- All outputs are registered.
- Start latency: I_start sampled high at edge N gives O_fe_data_valid=1 and O_busy=1 from edge N (visible in cycle N+1) with byte 0.
- Throughput: with gap = 0 and I_fe_ready held at 1, one byte per cycle with no bubbles, including across pass boundaries.
- With gap = G: G cycles with valid low between consecutive accepted bytes, including between passes.
- Completion: acceptance of the final byte at edge M gives:
  - O_fe_data_valid=0, O_busy=0 and O_done=1 from edge M, for one cycle.
  - A new I_start is accepted at edge M+1.
- Zero-length start at edge N: O_done=1 for one cycle after edge N; O_busy stays 0.

## Test plan
- Basic transfer:
  - Stimulus: len=4, I_pattern[31:0]=0x44332211, gap=0, repeat=0, ready=1.
  - Response: bytes 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting the cycle after start; O_done pulses once, the cycle after 0x44.
- Backpressure:
  - Stimulus: same configuration, ready low for 3 cycles while byte 0x22 is presented.
  - Response: 0x22 held stable with valid high; total 7 valid cycles; byte order unchanged.
- Gap and repeat:
  - Stimulus: len=2 (0xAA,0xBB), gap=2, repeat=1.
  - Response: AA,-,-,BB,-,-,AA,-,-,BB; O_done after the final BB; 4 bytes total.
- Clamp and zero length:
  - Stimulus: len=20 with pPATTERN_BYTES=8.
  - Response: exactly 8 bytes.
  - Stimulus: len=0.
  - Response: O_done pulse, no valid.
- Abort and reset:
  - Stimulus: abort during byte 2 of 8.
  - Response: valid low the next cycle, no O_done, a restart sends from byte 0.
  - Stimulus: reset_i asserted mid-GAP.
  - Response: all outputs 0 immediately.
- Loopback:
  - Stimulus: drive the matcher byte stream from this block with matching pattern and mask 0xFF..FF, matcher armed.
  - Response: matcher match asserts after the final pattern byte.

Source files
------------

// File: rtl/pw_pattern_sender_if.sv
`default_nettype none
// ============================================================================
// Module      : pw_pattern_sender_if
// Description : Byte-stream valid/ready bundle between the pattern sender
//               and a downstream consumer such as the front-end matcher.
//               fe_data        - current byte
//               fe_data_valid  - byte present
//               fe_ready       - downstream accepts when high with valid
//               master : byte producer (drives data/valid, reads ready)
//               slave  : byte consumer (reads data/valid, drives ready)
// Revision    : 1.0 - initial release
// ============================================================================
interface pw_pattern_sender_if;
  logic [7:0] fe_data;
  logic       fe_data_valid;
  logic       fe_ready;

  modport master (
    output fe_data,
    output fe_data_valid,
    input  fe_ready
  );

  modport slave (
    input  fe_data,
    input  fe_data_valid,
    output fe_ready
  );
endinterface
`default_nettype wire

// File: rtl/pw_pattern_sender.sv
`default_nettype none
// ============================================================================
// Module      : pw_pattern_sender
// Description : Byte-stream pattern transmitter. On a start request it
//               latches a pattern of up to pPATTERN_BYTES bytes together
//               with length, inter-byte gap and repeat count, then plays the
//               pattern (byte 0 = I_pattern[7:0]) onto a valid/ready byte
//               interface, (I_repeat+1) times, inserting I_gap idle cycles
//               after every accepted byte except the last one.
//
// Ports       : fe_clk          - clock, rising edge
//               reset_i         - asynchronous active-high reset
//               I_start         - one-cycle start request (ignored when busy)
//               I_abort         - stop the current transfer, highest priority
//               I_pattern       - pattern bytes, byte k = [8k+7:8k]
//               I_pattern_bytes - byte count, clamped to pPATTERN_BYTES
//               I_gap           - idle cycles after each non-final byte
//               I_repeat        - extra passes (0 = send once)
//               fe              - byte stream (master side)
//               O_busy          - transfer in progress
//               O_done          - one-cycle pulse on normal completion
// Revision    : 1.0 - initial release
// ============================================================================
module pw_pattern_sender #(
  parameter int pPATTERN_BYTES = 8
) (
  input  logic                        fe_clk,
  input  logic                        reset_i,
  input  logic                        I_start,
  input  logic                        I_abort,
  input  logic [pPATTERN_BYTES*8-1:0] I_pattern,
  input  logic [7:0]                  I_pattern_bytes,
  input  logic [7:0]                  I_gap,
  input  logic [7:0]                  I_repeat,
  pw_pattern_sender_if.master         fe,
  output logic                        O_busy,
  output logic                        O_done
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int         c_IDX_W   = (pPATTERN_BYTES > 1) ? $clog2(pPATTERN_BYTES) : 1;
  localparam logic [7:0] c_MAX_LEN = 8'(pPATTERN_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State and latched configuration
  // --------------------------------------------------------------------------
  state_t               r_state;
  logic [7:0]           r_pat [pPATTERN_BYTES];
  logic [c_IDX_W-1:0]   r_last_idx;   // latched length minus one
  logic [7:0]           r_gap;
  logic [7:0]           r_repeat;
  logic [c_IDX_W-1:0]   r_idx;        // byte being presented / next to present
  logic [7:0]           r_pass;       // 0 .. r_repeat, never exceeds r_repeat
  logic [7:0]           r_gap_cnt;    // remaining idle cycles minus one

  logic [7:0]           r_data;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_done;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [7:0]           w_len_clamped;
  logic [c_IDX_W-1:0]   w_last_idx_new;
  logic                 w_idx_last;
  logic                 w_pass_last;
  logic [c_IDX_W-1:0]   w_idx_next;
  logic                 w_accept;

  assign w_len_clamped  = (I_pattern_bytes > c_MAX_LEN) ? c_MAX_LEN : I_pattern_bytes;
  // Only meaningful for a non-zero length; a zero-length start never
  // reaches SEND, so the wrapped value is never used.
  assign w_last_idx_new = c_IDX_W'(w_len_clamped - 8'd1);

  assign w_idx_last     = (r_idx == r_last_idx);
  assign w_pass_last    = (r_pass == r_repeat);
  assign w_idx_next     = w_idx_last ? '0 : (r_idx + c_IDX_W'(1));
  assign w_accept       = r_valid & fe.fe_ready;

  // --------------------------------------------------------------------------
  // Sequencer: single registered process, every output is a flop.
  // --------------------------------------------------------------------------
  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= ST_IDLE;
      for (int k = 0; k < pPATTERN_BYTES; k++) begin
        r_pat[k] <= '0;
      end
      r_last_idx <= '0;
      r_gap      <= '0;
      r_repeat   <= '0;
      r_idx      <= '0;
      r_pass     <= '0;
      r_gap_cnt  <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (I_abort) begin
      // Abort beats everything, including a start arriving in IDLE. A byte
      // handshaken in this cycle is already delivered; we simply stop.
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        // DONE behaves like IDLE for new starts: busy is already low, so a
        // start in the completion-pulse cycle is accepted back to back.
        ST_IDLE, ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
          if (I_start) begin
            for (int k = 0; k < pPATTERN_BYTES; k++) begin
              r_pat[k] <= I_pattern[8*k +: 8];
            end
            r_last_idx <= w_last_idx_new;
            r_gap      <= I_gap;
            r_repeat   <= I_repeat;
            r_idx      <= '0;
            r_pass     <= '0;
            if (w_len_clamped != 8'd0) begin
              // Byte 0 comes straight from the live input so it appears in
              // the very first cycle after the start edge.
              r_state <= ST_SEND;
              r_data  <= I_pattern[7:0];
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end

        ST_SEND: begin
          // Without a handshake nothing changes: data and valid hold.
          if (w_accept) begin
            if (w_idx_last && w_pass_last) begin
              r_state <= ST_DONE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= w_idx_next;
              if (w_idx_last) begin
                r_pass <= r_pass + 8'd1;
              end
              if (r_gap == 8'd0) begin
                r_data <= r_pat[w_idx_next];
              end else begin
                r_state   <= ST_GAP;
                r_valid   <= 1'b0;
                // Loaded with gap-1 so the return to SEND lands exactly
                // r_gap cycles after valid dropped.
                r_gap_cnt <= r_gap - 8'd1;
              end
            end
          end
        end

        ST_GAP: begin
          if (r_gap_cnt == 8'd0) begin
            r_state <= ST_SEND;
            r_data  <= r_pat[r_idx];
            r_valid <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign fe.fe_data       = r_data;
  assign fe.fe_data_valid = r_valid;
  assign O_busy           = r_busy;
  assign O_done           = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pw_pattern_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_pw_pattern_sender
// Description : Self-checking bench for pw_pattern_sender. Expected byte
//               streams come from a list-based model (pattern bytes repeated
//               per pass); observed streams are collected from the valid/
//               ready interface with randomized backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pw_pattern_sender;
  localparam int P = 8;

  logic         fe_clk = 1'b0;
  logic         reset_i;
  logic         I_start;
  logic         I_abort;
  logic [P*8-1:0] I_pattern;
  logic [7:0]   I_pattern_bytes;
  logic [7:0]   I_gap;
  logic [7:0]   I_repeat;
  logic         O_busy;
  logic         O_done;

  always #5 fe_clk = ~fe_clk;

  pw_pattern_sender_if fe_if ();

  pw_pattern_sender #(.pPATTERN_BYTES(P)) dut (
    .fe_clk          (fe_clk),
    .reset_i         (reset_i),
    .I_start         (I_start),
    .I_abort         (I_abort),
    .I_pattern       (I_pattern),
    .I_pattern_bytes (I_pattern_bytes),
    .I_gap           (I_gap),
    .I_repeat        (I_repeat),
    .fe              (fe_if),
    .O_busy          (O_busy),
    .O_done          (O_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Collector results
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         gap_q[$];
  int         done_cnt, done_ok, hold_err, valid_cycles, timeout;
  logic       first_valid, first_busy, first_done;
  logic [7:0] first_data;

  // Reference: pattern bytes 0..min(len,P)-1, repeated rep+1 times.
  function automatic void build_expect(input logic [P*8-1:0] pat, input int len, input int rep);
    int l;
    l = (len > P) ? P : len;
    exp_q.delete();
    for (int p = 0; p <= rep; p++)
      for (int k = 0; k < l; k++)
        exp_q.push_back(pat[8*k +: 8]);
  endfunction

  task automatic cfg(input logic [P*8-1:0] pat, input int len, input int gap, input int rep);
    I_pattern       = pat;
    I_pattern_bytes = 8'(len);
    I_gap           = 8'(gap);
    I_repeat        = 8'(rep);
  endtask

  // Pulses start, then plays consumer until O_done or the cycle budget.
  // Called and returns at #1 after a rising edge.
  task automatic run_xfer(input int ready_pct, input logic [7:0] stall_byte,
                          input int stall_n, input bit scramble, input int max_cyc);
    int   gap_run, stalled;
    bit   in_gap, prev_stalled, last_acc_prev, finished, r;
    logic [7:0] prev_data;
    got_q.delete(); gap_q.delete();
    done_cnt = 0; done_ok = 0; hold_err = 0; valid_cycles = 0; timeout = 0;
    gap_run = 0; stalled = 0; in_gap = 0; prev_stalled = 0; last_acc_prev = 0;
    finished = 0; prev_data = '0;
    I_start = 1'b1;
    @(posedge fe_clk); #1;
    I_start = 1'b0;
    first_valid = fe_if.fe_data_valid; first_data = fe_if.fe_data;
    first_busy  = O_busy;              first_done = O_done;
    if (scramble) begin
      I_pattern       = {$urandom, $urandom};
      I_pattern_bytes = 8'($urandom);
      I_gap           = 8'($urandom);
      I_repeat        = 8'($urandom);
    end
    for (int c = 0; c < max_cyc && !finished; c++) begin
      if (O_done) begin
        done_cnt++;
        if (last_acc_prev) done_ok = 1;
        finished = 1;
      end else if (fe_if.fe_data_valid) begin
        valid_cycles++;
        if (prev_stalled && fe_if.fe_data !== prev_data) hold_err++;
        if (in_gap) begin gap_q.push_back(gap_run); in_gap = 0; end
        if (fe_if.fe_data == stall_byte && stalled < stall_n) begin
          r = 1'b0; stalled++;
        end else begin
          r = ($urandom_range(99) < ready_pct);
        end
        fe_if.fe_ready = r;
        if (!r) I_start = 1'($urandom_range(1));  // must be ignored while busy
        prev_stalled = !r;
        prev_data    = fe_if.fe_data;
        if (r) begin got_q.push_back(fe_if.fe_data); in_gap = 1; gap_run = 0; end
        last_acc_prev = r;
      end else begin
        if (in_gap) gap_run++;
        fe_if.fe_ready = 1'($urandom_range(1));
        last_acc_prev = 0; prev_stalled = 0;
      end
      if (!finished) begin
        @(posedge fe_clk); #1;
        I_start = 1'b0;
      end
    end
    if (!finished) timeout = 1;
    fe_if.fe_ready = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(posedge fe_clk);
    #1;
    n_cmp++; if (fe_if.fe_data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", fe_if.fe_data_valid); end
    n_cmp++; if (fe_if.fe_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", fe_if.fe_data); end
    n_cmp++; if (O_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", O_busy); end
    n_cmp++; if (O_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", O_done); end
    reset_i = 1'b0;
    @(posedge fe_clk); #1;
  endtask

  task automatic test_basic();
    cfg(64'h0000_0000_4433_2211, 4, 0, 0);
    build_expect(64'h0000_0000_4433_2211, 4, 0);
    run_xfer(100, 8'h00, 0, 0, 100);
    n_cmp++; if (first_valid !== 1'b1 || first_data !== 8'h11) begin n_bad++; $display("FAIL basic_latency: got v=%b d=%h want v=1 d=11", first_valid, first_data); end
    n_cmp++; if (first_busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", first_busy); end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL basic_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL basic_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (valid_cycles != 4) begin n_bad++; $display("FAIL basic_valid_cycles: got %0d want 4", valid_cycles); end
    n_cmp++; if (done_cnt != 1 || done_ok != 1 || timeout != 0) begin n_bad++; $display("FAIL basic_done: got cnt=%0d next=%0d to=%0d want 1 1 0", done_cnt, done_ok, timeout); end
    n_cmp++; if (O_busy !== 1'b0 || fe_if.fe_data_valid !== 1'b0) begin n_bad++; $display("FAIL basic_done_outputs: got busy=%b v=%b want 0 0", O_busy, fe_if.fe_data_valid); end
    @(posedge fe_clk); #1;
    n_cmp++; if (O_done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width: got %b want 0", O_done); end
  endtask

  task automatic test_backpressure();
    cfg(64'h0000_0000_4433_2211, 4, 0, 0);
    build_expect(64'h0000_0000_4433_2211, 4, 0);
    run_xfer(100, 8'h22, 3, 0, 100);
    n_cmp++; if (valid_cycles != 7) begin n_bad++; $display("FAIL bp_valid_cycles: got %0d want 7", valid_cycles); end
    n_cmp++; if (hold_err != 0) begin n_bad++; $display("FAIL bp_hold: got %0d changes want 0", hold_err); end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (done_ok != 1) begin n_bad++; $display("FAIL bp_done: got %0d want 1", done_ok); end
  endtask

  task automatic test_gap_repeat();
    cfg(64'h0000_0000_0000_BBAA, 2, 2, 1);
    build_expect(64'h0000_0000_0000_BBAA, 2, 1);
    run_xfer(100, 8'h00, 0, 1, 200);
    n_cmp++; if (got_q.size() != 4) begin n_bad++; $display("FAIL gap_count: got %0d want 4", got_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL gap_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (gap_q.size() != 3) begin n_bad++; $display("FAIL gap_n: got %0d want 3", gap_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_cmp++; if (gap_q[i] != 2) begin n_bad++; $display("FAIL gap_len%0d: got %0d want 2", i, gap_q[i]); end
    end
    n_cmp++; if (done_ok != 1 || done_cnt != 1) begin n_bad++; $display("FAIL gap_done: got %0d/%0d want 1/1", done_ok, done_cnt); end
  endtask

  task automatic test_clamp_zero();
    cfg(64'h8877_6655_4433_2211, 20, 0, 0);
    build_expect(64'h8877_6655_4433_2211, 20, 0);
    run_xfer(100, 8'h00, 0, 0, 100);
    n_cmp++; if (got_q.size() != 8) begin n_bad++; $display("FAIL clamp_count: got %0d want 8", got_q.size()); end
    else for (int i = 0; i < 8; i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL clamp_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (done_ok != 1) begin n_bad++; $display("FAIL clamp_done: got %0d want 1", done_ok); end
    @(posedge fe_clk); #1;
    cfg(64'h8877_6655_4433_2211, 0, 3, 2);
    run_xfer(100, 8'h00, 0, 0, 20);
    n_cmp++; if (first_done !== 1'b1 || first_busy !== 1'b0 || first_valid !== 1'b0) begin n_bad++; $display("FAIL zero_first: got done=%b busy=%b v=%b want 1 0 0", first_done, first_busy, first_valid); end
    n_cmp++; if (got_q.size() != 0 || valid_cycles != 0) begin n_bad++; $display("FAIL zero_bytes: got %0d want 0", got_q.size()); end
    @(posedge fe_clk); #1;
    n_cmp++; if (O_done !== 1'b0) begin n_bad++; $display("FAIL zero_done_width: got %b want 0", O_done); end
  endtask

  task automatic test_abort();
    int guard;
    cfg(64'h8877_6655_4433_2211, 8, 0, 0);
    fe_if.fe_ready = 1'b1;
    I_start = 1'b1;
    @(posedge fe_clk); #1;
    I_start = 1'b0;
    guard = 0;
    while (!(fe_if.fe_data_valid && fe_if.fe_data == 8'h33) && guard < 20) begin
      @(posedge fe_clk); #1; guard++;
    end
    n_cmp++; if (guard >= 20) begin n_bad++; $display("FAIL abort_reach: got timeout want byte 33"); end
    I_abort = 1'b1;
    @(posedge fe_clk); #1;
    I_abort = 1'b0;
    n_cmp++; if (fe_if.fe_data_valid !== 1'b0 || O_busy !== 1'b0) begin n_bad++; $display("FAIL abort_stop: got v=%b busy=%b want 0 0", fe_if.fe_data_valid, O_busy); end
    guard = 0;
    for (int i = 0; i < 5; i++) begin
      if (O_done || fe_if.fe_data_valid) guard++;
      @(posedge fe_clk); #1;
    end
    n_cmp++; if (guard != 0) begin n_bad++; $display("FAIL abort_quiet: got %0d active cycles want 0", guard); end
    build_expect(64'h8877_6655_4433_2211, 8, 0);
    run_xfer(100, 8'h00, 0, 0, 100);
    n_cmp++; if (first_data !== 8'h11 || got_q.size() != 8) begin n_bad++; $display("FAIL abort_restart: got first=%h n=%0d want 11 8", first_data, got_q.size()); end
    // Start and abort together while idle: nothing starts.
    @(posedge fe_clk); #1;
    I_start = 1'b1; I_abort = 1'b1;
    @(posedge fe_clk); #1;
    I_start = 1'b0; I_abort = 1'b0;
    n_cmp++; if (O_busy !== 1'b0 || fe_if.fe_data_valid !== 1'b0 || O_done !== 1'b0) begin n_bad++; $display("FAIL abort_vs_start: got busy=%b v=%b done=%b want 0 0 0", O_busy, fe_if.fe_data_valid, O_done); end
  endtask

  task automatic test_reset_mid_gap();
    cfg(64'h0000_0000_0000_BBAA, 2, 5, 0);
    fe_if.fe_ready = 1'b1;
    I_start = 1'b1;
    @(posedge fe_clk); #1;
    I_start = 1'b0;
    @(posedge fe_clk); #1;
    n_cmp++; if (O_busy !== 1'b1 || fe_if.fe_data_valid !== 1'b0) begin n_bad++; $display("FAIL rst_in_gap: got busy=%b v=%b want 1 0", O_busy, fe_if.fe_data_valid); end
    #2;
    reset_i = 1'b1;
    #1;
    n_cmp++; if (O_busy !== 1'b0 || O_done !== 1'b0 || fe_if.fe_data_valid !== 1'b0 || fe_if.fe_data !== 8'h00) begin n_bad++; $display("FAIL rst_async: got busy=%b done=%b v=%b d=%h want 0 0 0 00", O_busy, O_done, fe_if.fe_data_valid, fe_if.fe_data); end
    @(negedge fe_clk);
    reset_i = 1'b0;
    repeat (7) @(posedge fe_clk);
    #1;
    n_cmp++; if (O_busy !== 1'b0 || fe_if.fe_data_valid !== 1'b0) begin n_bad++; $display("FAIL rst_stays_idle: got busy=%b v=%b want 0 0", O_busy, fe_if.fe_data_valid); end
  endtask

  task automatic test_random();
    logic [P*8-1:0] pat;
    int len, gap, rep;
    for (int it = 0; it < 12; it++) begin
      pat = {$urandom, $urandom};
      len = int'($urandom_range(12));
      gap = int'($urandom_range(3));
      rep = int'($urandom_range(3));
      cfg(pat, len, gap, rep);
      build_expect(pat, len, rep);
      run_xfer(60, 8'h00, 0, 1, 2000);
      n_cmp++; if (timeout != 0 || done_cnt != 1) begin n_bad++; $display("FAIL rnd%0d_done: got to=%0d cnt=%0d want 0 1", it, timeout, done_cnt); end
      n_cmp++; if (hold_err != 0) begin n_bad++; $display("FAIL rnd%0d_hold: got %0d want 0", it, hold_err); end
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rnd%0d_count: got %0d want %0d", it, got_q.size(), exp_q.size()); end
      else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rnd%0d_byte%0d: got %h want %h", it, i, got_q[i], exp_q[i]); end
        end
        if (exp_q.size() > 0) begin
          n_cmp++; if (done_ok != 1) begin n_bad++; $display("FAIL rnd%0d_done_timing: got %0d want 1", it, done_ok); end
          n_cmp++; if (gap_q.size() != exp_q.size() - 1) begin n_bad++; $display("FAIL rnd%0d_gap_n: got %0d want %0d", it, gap_q.size(), exp_q.size() - 1); end
          foreach (gap_q[i]) begin
            n_cmp++; if (gap_q[i] != gap) begin n_bad++; $display("FAIL rnd%0d_gap%0d: got %0d want %0d", it, i, gap_q[i], gap); end
          end
        end else begin
          n_cmp++; if (first_done !== 1'b1 || first_valid !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_zero: got done=%b v=%b want 1 0", it, first_done, first_valid); end
        end
      end
      @(posedge fe_clk); #1;
    end
  endtask

  // Behavioural matcher on the loopback stream: sliding window of the last
  // len bytes compared against the pattern under an all-ones mask.
  task automatic test_loopback();
    logic [P*8-1:0] pat;
    logic [P*8-1:0] mask;
    logic [P*8-1:0] win;
    bit match;
    pat  = {$urandom, $urandom};
    mask = '1;
    cfg(pat, P, int'($urandom_range(2)), 0);
    run_xfer(80, 8'h00, 0, 1, 500);
    win = '0;
    match = 0;
    foreach (got_q[i]) begin
      win   = {got_q[i], win[P*8-1:8]};
      match = (i >= P - 1) && ((win & mask) == (pat & mask));
    end
    n_cmp++; if (!match || got_q.size() != P) begin n_bad++; $display("FAIL loopback_match: got match=%0d n=%0d want 1 %0d", match, got_q.size(), P); end
    @(posedge fe_clk); #1;
  endtask

  initial begin
    reset_i = 1'b1; I_start = 1'b0; I_abort = 1'b0;
    I_pattern = '0; I_pattern_bytes = '0; I_gap = '0; I_repeat = '0;
    fe_if.fe_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_gap_repeat();
    test_clamp_zero();
    test_abort();
    test_reset_mid_gap();
    test_random();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
